// File: rtl/eclock_bus_sync.sv
// eclock_bus_sync: runs one 6800-style VPA/VMA peripheral cycle against the
// free-running E clock on behalf of the bus master. E is synchronized, its
// phase tracked from the last falling edge, and a watchdog flags a dead E.
module eclock_bus_sync #(
  parameter int SYNC_STAGES    = 2,
  parameter int VMA_LAST_PHASE = 3,
  parameter int E_TIMEOUT      = 32
) (
  input  logic       CLOCK_IN,
  input  logic       RESET_N,
  input  logic       ECLOCK_IN,
  input  logic       REQ_IN,
  output logic       VMA_N_OUT,
  output logic       LATCH_OUT,
  output logic       ACK_OUT,
  output logic       ERR_OUT,
  output logic       BUSY_OUT,
  output logic [3:0] E_PHASE_OUT
);

  localparam int              WD_W     = $clog2(E_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(E_TIMEOUT);
  localparam logic [3:0]      PH_MAX   = 4'hF;
  localparam logic [3:0]      VMA_LAST = 4'(VMA_LAST_PHASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_WAIT_RISE,
    S_E_HIGH,
    S_DONE,
    S_ERR
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   e_prev_q, e_prev_d;
  logic [3:0]             phase_q, phase_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  state_t                 state_q, state_d;
  logic                   vma_n_q, vma_n_d;
  logic                   latch_q, latch_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic e_s;
  logic rise;
  logic fall;
  logic dead;

  // Edge detection on the synchronized E and dead-clock flag from the watchdog
  always_comb begin
    e_s  = sync_q[SYNC_STAGES-1];
    rise = ~e_prev_q & e_s;
    fall = e_prev_q & ~e_s;
    dead = (wd_q == WD_MAX);
  end

  // Next-state for synchronizer, phase counter and watchdog
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], ECLOCK_IN};
    e_prev_d = e_s;
    phase_d  = phase_q;
    wd_d     = wd_q;
    if (fall) begin
      phase_d = '0;
    end else if (phase_q != PH_MAX) begin
      phase_d = phase_q + 4'd1;
    end
    if (rise || fall) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Cycle FSM next-state; a dropped request aborts before any dead-E error
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_IN) state_d = dead ? S_ERR : S_WAIT_SYNC;
      end
      S_WAIT_SYNC: begin
        if (!REQ_IN)                                         state_d = S_IDLE;
        else if (dead)                                       state_d = S_ERR;
        else if (!e_s && (phase_q <= VMA_LAST) && !fall)     state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (!REQ_IN)   state_d = S_IDLE;
        else if (dead) state_d = S_ERR;
        else if (rise) state_d = S_E_HIGH;
      end
      S_E_HIGH: begin
        if (!REQ_IN)   state_d = S_IDLE;
        else if (dead) state_d = S_ERR;
        else if (fall) state_d = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (!REQ_IN) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the transition being taken; strobes fire on entry only
  always_comb begin
    vma_n_d = !((state_d == S_WAIT_RISE) || (state_d == S_E_HIGH));
    ack_d   = (state_q == S_E_HIGH) && (state_d == S_DONE);
    latch_d = ack_d;
    err_d   = (state_q != S_ERR) && (state_d == S_ERR);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset starts with E declared dead
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q   <= '0;
      e_prev_q <= 1'b0;
      phase_q  <= PH_MAX;
      wd_q     <= WD_MAX;
      state_q  <= S_IDLE;
      vma_n_q  <= 1'b1;
      latch_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      e_prev_q <= e_prev_d;
      phase_q  <= phase_d;
      wd_q     <= wd_d;
      state_q  <= state_d;
      vma_n_q  <= vma_n_d;
      latch_q  <= latch_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign VMA_N_OUT   = vma_n_q;
  assign LATCH_OUT   = latch_q;
  assign ACK_OUT     = ack_q;
  assign ERR_OUT     = err_q;
  assign BUSY_OUT    = busy_q;
  assign E_PHASE_OUT = phase_q;

endmodule

// File: tb/tb_eclock_bus_sync.sv
// Bench for eclock_bus_sync: directed vector table, hand-written corner
// sequences and random E/request traffic against a history-based model.
module tb_eclock_bus_sync;

  localparam int S = 2;
  localparam int L = 3;
  localparam int T = 32;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       ECLOCK_IN;
  logic       REQ_IN;
  logic       VMA_N_OUT;
  logic       LATCH_OUT;
  logic       ACK_OUT;
  logic       ERR_OUT;
  logic       BUSY_OUT;
  logic [3:0] E_PHASE_OUT;

  always #5 clk = ~clk;

  eclock_bus_sync #(
    .SYNC_STAGES(S),
    .VMA_LAST_PHASE(L),
    .E_TIMEOUT(T)
  ) dut (
    .CLOCK_IN(clk),
    .RESET_N(RESET_N),
    .ECLOCK_IN(ECLOCK_IN),
    .REQ_IN(REQ_IN),
    .VMA_N_OUT(VMA_N_OUT),
    .LATCH_OUT(LATCH_OUT),
    .ACK_OUT(ACK_OUT),
    .ERR_OUT(ERR_OUT),
    .BUSY_OUT(BUSY_OUT),
    .E_PHASE_OUT(E_PHASE_OUT)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int epos     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // E samples since reset; synchronized views are derived by looking back
  // into this history rather than by modelling individual flops.
  int hist[$];
  bit m_busy, m_granted, m_rise_seen, m_finished;
  bit x_vma_n, x_ack, x_err;
  int x_phase;

  function automatic int h(input int k);
    if (k < 1 || k > hist.size()) return 0;
    return hist[k-1];
  endfunction

  function automatic bit fall_at(input int m);
    return (h(m-S-1) == 1) && (h(m-S) == 0);
  endfunction

  function automatic bit edge_at(input int m);
    return h(m-S-1) != h(m-S);
  endfunction

  // Edges since the last fall (or any edge), capped
  function automatic int since(input int n, input bit falls_only, input int cap);
    for (int m = n; m >= 1 && m >= n - cap; m--) begin
      if (falls_only ? fall_at(m) : edge_at(m)) return n - m;
    end
    return cap;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_busy = 0; m_granted = 0; m_rise_seen = 0; m_finished = 0;
    x_vma_n = 1; x_ack = 0; x_err = 0; x_phase = 15;
  endtask

  task automatic model_step(input logic e, input logic r);
    int  n, phase_pre;
    bit  e_s, fall, rise, dead;
    hist.push_back(int'(e));
    n         = hist.size();
    e_s       = h(n-S) != 0;
    fall      = fall_at(n);
    rise      = edge_at(n) && !fall;
    phase_pre = since(n-1, 1'b1, 15);
    dead      = since(n-1, 1'b0, T) == T;
    x_ack = 0;
    x_err = 0;
    if (!m_busy) begin
      if (r) begin
        m_busy = 1;
        if (dead) begin m_finished = 1; x_err = 1; end
      end
    end else if (m_finished) begin
      if (!r) begin m_busy = 0; m_finished = 0; end
    end else if (!r) begin
      m_busy = 0; m_granted = 0; m_rise_seen = 0;
    end else if (dead) begin
      x_err = 1; m_finished = 1; m_granted = 0; m_rise_seen = 0;
    end else if (!m_granted) begin
      if (!e_s && phase_pre <= L && !fall) m_granted = 1;
    end else if (!m_rise_seen) begin
      if (rise) m_rise_seen = 1;
    end else if (fall) begin
      x_ack = 1; m_finished = 1; m_granted = 0; m_rise_seen = 0;
    end
    x_vma_n = !m_granted;
    x_phase = since(n, 1'b1, 15);
  endtask

  function automatic logic [8:0] dut_out();
    return {VMA_N_OUT, LATCH_OUT, ACK_OUT, ERR_OUT, BUSY_OUT, E_PHASE_OUT};
  endfunction

  // One clock: drive inputs, advance model at the edge, compare at the negedge
  task automatic tick(input logic e, input logic r);
    logic [8:0] exp_v;
    ECLOCK_IN = e;
    REQ_IN    = r;
    @(posedge clk);
    model_step(e, r);
    @(negedge clk);
    exp_v = {x_vma_n, x_ack, x_ack, x_err, m_busy, 4'(x_phase)};
    check("model", 32'(dut_out()), 32'(exp_v));
    check("exclusive", 32'({ACK_OUT & ERR_OUT, LATCH_OUT & ~ACK_OUT}), 32'(0));
  endtask

  task automatic tick_nom(input logic r);
    tick(((epos % 10) >= 6), r);
    epos++;
  endtask

  task automatic wait_phase(input int target, input logic r, input int budget);
    int k = 0;
    while (int'(E_PHASE_OUT) != target && k < budget) begin
      tick_nom(r);
      k++;
    end
    check("wait_phase", 32'(E_PHASE_OUT), 32'(target));
  endtask

  typedef struct {
    logic e;
    logic req;
    logic vma_n;
    logic ack;
    logic err;
    logic busy;
    int   phase;
  } vec_t;

  vec_t tbl[26];

  initial begin
    int vma_at, ack_at, err_cnt, vma_low, ack_cnt, busy_low;
    logic r, e_lvl;
    int e_left;

    // Nominal cycle straight out of reset, E = 6 low / 4 high
    for (int i = 0; i < 12; i++) tbl[i] = '{(i % 10) >= 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9};
    tbl[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};
    tbl[23] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[25] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};

    RESET_N   = 1'b0;
    ECLOCK_IN = 1'b0;
    REQ_IN    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(dut_out()), 32'(9'b1_0000_1111));
    RESET_N = 1'b1;
    model_reset();

    for (int i = 0; i < 26; i++) begin
      tick(tbl[i].e, tbl[i].req);
      check($sformatf("table[%0d]", i), 32'(dut_out()),
            32'({tbl[i].vma_n, tbl[i].ack, tbl[i].ack, tbl[i].err, tbl[i].busy, 4'(tbl[i].phase)}));
    end
    epos = 26;

    // Late request: sampled at phase 5, granted next period
    wait_phase(5, 1'b0, 20);
    tick_nom(1'b1);
    vma_at = -1; ack_at = -1; ack_cnt = 0;
    for (int k = 1; k <= 30 && ack_at < 0; k++) begin
      tick_nom(1'b1);
      if (!VMA_N_OUT && vma_at < 0) vma_at = k;
      if (ACK_OUT) begin ack_at = k; ack_cnt++; end
    end
    check("late_vma_at", 32'(vma_at), 32'(5));
    check("late_ack_at", 32'(ack_at), 32'(14));
    tick_nom(1'b0);

    // Dead E then a request
    repeat (40) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("dead_err_first", 32'(ERR_OUT), 32'(1));
    err_cnt = int'(ERR_OUT); vma_low = int'(!VMA_N_OUT);
    repeat (5) begin
      tick(1'b0, 1'b1);
      err_cnt += int'(ERR_OUT);
      vma_low += int'(!VMA_N_OUT);
    end
    check("dead_err_count", 32'(err_cnt), 32'(1));
    check("dead_vma_low", 32'(vma_low), 32'(0));
    tick(1'b0, 1'b0);
    check("dead_busy_clear", 32'(BUSY_OUT), 32'(0));

    // Abort in E_HIGH, then a normal cycle
    epos = 0;
    repeat (25) tick_nom(1'b0);
    wait_phase(1, 1'b0, 20);
    tick_nom(1'b1);
    wait_phase(7, 1'b1, 20);
    check("abort_vma_before", 32'(VMA_N_OUT), 32'(0));
    tick_nom(1'b0);
    check("abort_vma_after", 32'({VMA_N_OUT, BUSY_OUT}), 32'(2'b10));
    ack_cnt = 0;
    repeat (12) begin
      tick_nom(1'b0);
      ack_cnt += int'(ACK_OUT) + int'(LATCH_OUT);
    end
    check("abort_no_ack", 32'(ack_cnt), 32'(0));
    wait_phase(1, 1'b0, 20);
    tick_nom(1'b1);
    ack_at = -1;
    for (int k = 1; k <= 30 && ack_at < 0; k++) begin
      tick_nom(1'b1);
      if (ACK_OUT) ack_at = k;
    end
    check("after_abort_ack_at", 32'(ack_at), 32'(8));

    // Held request: single ack, busy until REQ_IN falls
    ack_cnt = 1; busy_low = 0;
    repeat (30) begin
      tick_nom(1'b1);
      ack_cnt  += int'(ACK_OUT);
      busy_low += int'(!BUSY_OUT);
    end
    check("held_ack_count", 32'(ack_cnt), 32'(1));
    check("held_busy_low", 32'(busy_low), 32'(0));
    tick_nom(1'b0);
    check("held_busy_clear", 32'(BUSY_OUT), 32'(0));

    // Async reset while waiting for the E rise
    wait_phase(1, 1'b0, 20);
    tick_nom(1'b1);
    tick_nom(1'b1);
    check("rst_vma_before", 32'(VMA_N_OUT), 32'(0));
    #2 RESET_N = 1'b0;
    REQ_IN    = 1'b0;
    ECLOCK_IN = 1'b0;
    #1 check("rst_async", 32'({VMA_N_OUT, BUSY_OUT, E_PHASE_OUT}), 32'(6'b10_1111));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    RESET_N = 1'b1;
    tick(1'b0, 1'b1);
    check("rst_err_pulse", 32'(ERR_OUT), 32'(1));
    tick(1'b0, 1'b1);
    check("rst_err_once", 32'(ERR_OUT), 32'(0));
    tick(1'b0, 1'b0);
    check("rst_busy_clear", 32'(BUSY_OUT), 32'(0));

    // Random E (irregular and occasional stalls) and random request behaviour
    r = 1'b0; e_lvl = 1'b0; e_left = 3;
    for (int c = 0; c < 3000; c++) begin
      if (e_left == 0) begin
        e_lvl  = ~e_lvl;
        e_left = e_lvl ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 9));
        if ($urandom_range(0, 29) == 0) e_left = int'($urandom_range(34, 45));
      end
      e_left--;
      if (!r)              r = ($urandom_range(0, 3) == 0);
      else if (m_finished) r = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 39) == 0) r = 1'b0;
      tick(e_lvl, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
